// File: rtl/sc_player_position_reg.sv
// One-hot player position register with edge comparators, move counter and blocked-shift pulse.
// Optional build macro SC_PLAYERPOS_WRAP_EN: shifts at an edge rotate instead of being refused.
module sc_player_position_reg #(
  parameter int DATAWIDTH = 8,
  parameter int INIT_POS  = 3
) (
  input  logic                 SC_PLAYERPOS_CLOCK_50,
  input  logic                 SC_PLAYERPOS_RESET_InLow,
  input  logic                 SC_PLAYERPOS_clear_InLow,
  input  logic                 SC_PLAYERPOS_load0_InLow,
  input  logic                 SC_PLAYERPOS_load1_InLow,
  input  logic [1:0]           SC_PLAYERPOS_shiftselection_In,
  input  logic [DATAWIDTH-1:0] SC_PLAYERPOS_data_In,
  output logic [DATAWIDTH-1:0] SC_PLAYERPOS_data_Out,
  output logic                 SC_PLAYERPOS_izquierdacomparator_OutLow,
  output logic                 SC_PLAYERPOS_derechacomparator_OutLow,
  output logic                 SC_PLAYERPOS_blocked_Out,
  output logic                 SC_PLAYERPOS_onehot_error_Out,
  output logic [7:0]           SC_PLAYERPOS_moves_Out
);

  localparam logic [DATAWIDTH-1:0] INIT_WORD = DATAWIDTH'(1) << INIT_POS;

`ifdef SC_PLAYERPOS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [DATAWIDTH-1:0] ckpt_q, ckpt_d;
  logic [7:0]           moves_q, moves_d;
  logic                 blocked_q, blocked_d;
  logic                 data_onehot;
  logic [7:0]           moves_inc;

  function automatic logic is_onehot(input logic [DATAWIDTH-1:0] v);
    return (v != '0) && ((v & (v - DATAWIDTH'(1))) == '0);
  endfunction

  assign data_onehot = is_onehot(data_q);
  assign moves_inc   = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;

  always_comb begin
    data_d    = data_q;
    ckpt_d    = ckpt_q;
    moves_d   = moves_q;
    blocked_d = 1'b0;
    if (!SC_PLAYERPOS_clear_InLow) begin
      data_d  = INIT_WORD;
      ckpt_d  = INIT_WORD;
      moves_d = 8'd0;
    end else if (!SC_PLAYERPOS_load0_InLow) begin
      data_d = SC_PLAYERPOS_data_In;
      if (is_onehot(SC_PLAYERPOS_data_In)) ckpt_d = SC_PLAYERPOS_data_In;
    end else if (!SC_PLAYERPOS_load1_InLow) begin
      data_d = ckpt_q;
    end else begin
      // Rotation equals a plain shift whenever the edge bit is clear, so one expression serves both builds.
      case (SC_PLAYERPOS_shiftselection_In)
        2'b01: begin
          if (data_onehot && (WRAP || !data_q[DATAWIDTH-1])) begin
            data_d  = {data_q[DATAWIDTH-2:0], data_q[DATAWIDTH-1]};
            moves_d = moves_inc;
          end else begin
            blocked_d = 1'b1;
          end
        end
        2'b10: begin
          if (data_onehot && (WRAP || !data_q[0])) begin
            data_d  = {data_q[0], data_q[DATAWIDTH-1:1]};
            moves_d = moves_inc;
          end else begin
            blocked_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SC_PLAYERPOS_CLOCK_50 or negedge SC_PLAYERPOS_RESET_InLow) begin
    if (!SC_PLAYERPOS_RESET_InLow) begin
      data_q    <= '0;
      ckpt_q    <= '0;
      moves_q   <= 8'd0;
      blocked_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      ckpt_q    <= ckpt_d;
      moves_q   <= moves_d;
      blocked_q <= blocked_d;
    end
  end

  assign SC_PLAYERPOS_data_Out         = data_q;
  assign SC_PLAYERPOS_moves_Out        = moves_q;
  assign SC_PLAYERPOS_blocked_Out      = blocked_q;
  assign SC_PLAYERPOS_onehot_error_Out = ~data_onehot;

`ifdef SC_PLAYERPOS_WRAP_EN
  assign SC_PLAYERPOS_izquierdacomparator_OutLow = 1'b1;
  assign SC_PLAYERPOS_derechacomparator_OutLow   = 1'b1;
`else
  assign SC_PLAYERPOS_izquierdacomparator_OutLow = ~data_q[DATAWIDTH-1];
  assign SC_PLAYERPOS_derechacomparator_OutLow   = ~data_q[0];
`endif

endmodule

// File: tb/tb_sc_player_position_reg.sv
// Directed self-checking bench for sc_player_position_reg (DATAWIDTH=8, INIT_POS=3).
module tb_sc_player_position_reg;

`ifdef SC_PLAYERPOS_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       clear_n;
  logic       load0_n;
  logic       load1_n;
  logic [1:0] shift;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       izq;
  logic       der;
  logic       blocked;
  logic       oh_err;
  logic [7:0] moves;

  int checks   = 0;
  int failures = 0;

  sc_player_position_reg #(.DATAWIDTH(8), .INIT_POS(3)) dut (
    .SC_PLAYERPOS_CLOCK_50                   (clk),
    .SC_PLAYERPOS_RESET_InLow                (rst_n),
    .SC_PLAYERPOS_clear_InLow                (clear_n),
    .SC_PLAYERPOS_load0_InLow                (load0_n),
    .SC_PLAYERPOS_load1_InLow                (load1_n),
    .SC_PLAYERPOS_shiftselection_In          (shift),
    .SC_PLAYERPOS_data_In                    (data_in),
    .SC_PLAYERPOS_data_Out                   (data_out),
    .SC_PLAYERPOS_izquierdacomparator_OutLow (izq),
    .SC_PLAYERPOS_derechacomparator_OutLow   (der),
    .SC_PLAYERPOS_blocked_Out                (blocked),
    .SC_PLAYERPOS_onehot_error_Out           (oh_err),
    .SC_PLAYERPOS_moves_Out                  (moves)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b1;
    clear_n = 1'b1;
    load0_n = 1'b1;
    load1_n = 1'b1;
    shift   = 2'b00;
    data_in = 8'h00;

    // 1. asynchronous reset between edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", data_out, 8'h00);
    chk("rst_moves", moves, 8'h00);
    chk("rst_izq", izq, 1'b1);
    chk("rst_der", der, 1'b1);
    chk("rst_blocked", blocked, 1'b0);
    chk("rst_oherr", oh_err, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_hold_data", data_out, 8'h00);

    // 2. left run to the edge
    clear_n = 1'b0;
    step();
    chk("clr_data", data_out, 8'h08);
    chk("clr_moves", moves, 8'h00);
    chk("clr_oherr", oh_err, 1'b0);
    clear_n = 1'b1;
    shift   = 2'b01;
    step(); chk("left1", data_out, 8'h10);
    step(); chk("left2", data_out, 8'h20);
    step(); chk("left3", data_out, 8'h40);
    step(); chk("left4", data_out, 8'h80);
    chk("left4_moves", moves, 8'd4);
    chk("left4_izq", izq, WRAP ? 1'b1 : 1'b0);
    chk("left4_blocked", blocked, 1'b0);
    step();
    chk("left5_data", data_out, WRAP ? 8'h01 : 8'h80);
    chk("left5_moves", moves, WRAP ? 8'd5 : 8'd4);
    chk("left5_blocked", blocked, WRAP ? 1'b0 : 1'b1);
    shift = 2'b00;
    step();
    chk("left_blocked_drop", blocked, 1'b0);

    // 3. simultaneous commands: clear wins
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    shift   = 2'b01;
    step(); step();
    chk("sim_pre", data_out, 8'h20);
    clear_n = 1'b0;
    load0_n = 1'b0;
    data_in = 8'hFF;
    shift   = 2'b10;
    step();
    chk("sim_data", data_out, 8'h08);
    chk("sim_moves", moves, 8'h00);
    clear_n = 1'b1;
    load0_n = 1'b1;
    shift   = 2'b00;

    // 4. bad load and restore
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    shift   = 2'b01;
    step(); step();
    chk("bad_pre", data_out, 8'h20);
    shift   = 2'b00;
    load0_n = 1'b0;
    data_in = 8'h05;
    step();
    chk("bad_data", data_out, 8'h05);
    chk("bad_oherr", oh_err, 1'b1);
    chk("bad_moves", moves, 8'd2);
    load0_n = 1'b1;
    shift   = 2'b10;
    step();
    chk("bad_shift_data", data_out, 8'h05);
    chk("bad_shift_blocked", blocked, 1'b1);
    chk("bad_shift_moves", moves, 8'd2);
    shift   = 2'b00;
    load1_n = 1'b0;
    step();
    chk("restore_data", data_out, 8'h08);
    chk("restore_oherr", oh_err, 1'b0);
    chk("restore_blocked", blocked, 1'b0);
    load1_n = 1'b1;

    // good one-hot load then restore returns that load
    load0_n = 1'b0;
    data_in = 8'h40;
    step();
    load0_n = 1'b1;
    shift   = 2'b10;
    step();
    chk("ckpt_shift", data_out, 8'h20);
    shift   = 2'b00;
    load1_n = 1'b0;
    step();
    chk("ckpt_restore", data_out, 8'h40);
    load1_n = 1'b1;

    // 5. right edge
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    shift   = 2'b10;
    step(); chk("right1", data_out, 8'h04);
    step(); chk("right2", data_out, 8'h02);
    step(); chk("right3", data_out, 8'h01);
    chk("right3_der", der, WRAP ? 1'b1 : 1'b0);
    chk("right3_izq", izq, 1'b1);
    step();
    chk("right4_data", data_out, WRAP ? 8'h80 : 8'h01);
    chk("right4_blocked", blocked, WRAP ? 1'b0 : 1'b1);
    chk("right4_moves", moves, WRAP ? 8'd4 : 8'd3);

    // reset mid-operation, between edges
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_moves", moves, 8'h00);
    chk("midrst_blocked", blocked, 1'b0);
    step();
    rst_n = 1'b1;
    shift = 2'b00;
    step();

    // move counter saturation
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    load0_n = 1'b0;
    data_in = 8'h01;
    step();
    chk("sat_load", data_out, 8'h01);
    load0_n = 1'b1;
    for (int r = 0; r < 20; r++) begin
      shift = 2'b01;
      repeat (7) step();
      shift = 2'b10;
      repeat (7) step();
      if (r == 0) chk("sat_round1", moves, 8'd14);
    end
    chk("sat_data", data_out, 8'h01);
    chk("sat_moves", moves, 8'hFF);
    shift = 2'b01;
    step();
    chk("sat_more_data", data_out, 8'h02);
    chk("sat_more_moves", moves, 8'hFF);
    chk("sat_blocked", blocked, 1'b0);
    shift = 2'b00;

`ifdef SC_PLAYERPOS_WRAP_EN
    // 6. rotate from the left edge
    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    load0_n = 1'b0;
    data_in = 8'h80;
    step();
    load0_n = 1'b1;
    shift   = 2'b01;
    step();
    chk("wrap_data", data_out, 8'h01);
    chk("wrap_moves", moves, 8'd1);
    chk("wrap_blocked", blocked, 1'b0);
    chk("wrap_izq", izq, 1'b1);
    chk("wrap_der", der, 1'b1);
    shift = 2'b00;
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
